// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and index helpers for the multi-port register file
package regfile_pkg;
  localparam int XZR = 31;
  localparam int DEF_XLEN = 64;
  localparam int DEF_NUM_REGS = 32;
  function automatic int lo(input int k, input int w);
    return k * w;
  endfunction
  // True when idx names a real, writable register (in range and not the hardwired zero).
  function automatic logic reg_ok(input int idx, input int num_regs, input int zero_en, input int zero_reg);
    return idx < num_regs && !(zero_en != 0 && idx == zero_reg);
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with alloc-over-write priority and per-port lookup
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int ZERO_EN = 1,
  parameter int ZERO_REG = XZR,
  parameter int BYPASS = 1,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_idx,
  input  logic                     alloc,
  input  logic [ADDR_W-1:0]        alloc_idx,
  input  logic [NUM_RD*ADDR_W-1:0] rd_idx,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [NUM_REGS-1:0]      busy_vec
);
  logic [NUM_REGS-1:0] busy_nxt;
  always_comb begin
    busy_nxt = busy_vec;
    for (int k = 0; k < NUM_WR; k++)
      if (wr_en[k] && reg_ok(int'(wr_idx[lo(k, ADDR_W) +: ADDR_W]), NUM_REGS, ZERO_EN, ZERO_REG))
        busy_nxt[wr_idx[lo(k, ADDR_W) +: ADDR_W]] = 1'b0;
    if (alloc && reg_ok(int'(alloc_idx), NUM_REGS, ZERO_EN, ZERO_REG))
      busy_nxt[alloc_idx] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) busy_vec <= '0;
    else busy_vec <= busy_nxt;
  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic hit;
    assign idx = rd_idx[j*ADDR_W +: ADDR_W];
    always_comb begin
      hit = 1'b0;
      for (int k = 0; k < NUM_WR; k++)
        hit = hit | (wr_en[k] && wr_idx[lo(k, ADDR_W) +: ADDR_W] == idx);
    end
    assign rd_busy[j] = reg_ok(int'(idx), NUM_REGS, ZERO_EN, ZERO_REG) && !(BYPASS != 0 && hit) && busy_vec[idx];
  end
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: parametrised multi-port register file with zero register, bypass and scoreboard
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int ZERO_EN = 1,
  parameter int ZERO_REG = XZR,
  parameter int BYPASS = 1,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_WR-1:0]        REG_WRITE,
  input  logic [NUM_WR*ADDR_W-1:0] write_reg,
  input  logic [NUM_WR*XLEN-1:0]   writeData,
  input  logic [NUM_RD*ADDR_W-1:0] read_reg,
  output logic [NUM_RD*XLEN-1:0]   read_data,
  output logic [NUM_RD-1:0]        read_busy,
  input  logic                     ALLOC,
  input  logic [ADDR_W-1:0]        alloc_reg,
  output logic [NUM_REGS-1:0]      busy_vec
);
  logic [XLEN-1:0] regs [NUM_REGS];
  // Later ports overwrite earlier ones in the same edge, so the highest port wins.
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++)
        if (REG_WRITE[k] && reg_ok(int'(write_reg[lo(k, ADDR_W) +: ADDR_W]), NUM_REGS, ZERO_EN, ZERO_REG))
          regs[write_reg[lo(k, ADDR_W) +: ADDR_W]] <= writeData[lo(k, XLEN) +: XLEN];
    end
  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic [XLEN-1:0] fwd;
    logic hit;
    assign idx = read_reg[j*ADDR_W +: ADDR_W];
    always_comb begin
      hit = 1'b0;
      fwd = '0;
      for (int k = 0; k < NUM_WR; k++)
        if (REG_WRITE[k] && write_reg[lo(k, ADDR_W) +: ADDR_W] == idx) begin
          hit = 1'b1;
          fwd = writeData[lo(k, XLEN) +: XLEN];
        end
    end
    assign read_data[j*XLEN +: XLEN] = (RESET || !reg_ok(int'(idx), NUM_REGS, ZERO_EN, ZERO_REG)) ? '0 :
                                       (BYPASS != 0 && hit) ? fwd : regs[idx];
  end
  regfile_scoreboard #(
    .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
    .ZERO_EN(ZERO_EN), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_sb (
    .clk(CLK), .rst(RESET), .wr_en(REG_WRITE), .wr_idx(write_reg),
    .alloc(ALLOC), .alloc_idx(alloc_reg), .rd_idx(read_reg),
    .rd_busy(read_busy), .busy_vec(busy_vec)
  );
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed checks on a 2-write bypassing instance and a 32-bit 4-read non-bypassing instance
module tb_register_file_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  logic [1:0]   a_we = '0;
  logic [9:0]   a_wr = '0;
  logic [127:0] a_wd = '0;
  logic [9:0]   a_rr = '0;
  logic [127:0] a_rd;
  logic [1:0]   a_rb;
  logic         a_al = 1'b0;
  logic [4:0]   a_ar = '0;
  logic [31:0]  a_bv;
  logic [0:0]   b_we = '0;
  logic [4:0]   b_wr = '0;
  logic [31:0]  b_wd = '0;
  logic [19:0]  b_rr = '0;
  logic [127:0] b_rd;
  logic [3:0]   b_rb;
  logic         b_al = 1'b0;
  logic [4:0]   b_ar = '0;
  logic [19:0]  b_bv;
  register_file_mp #(.XLEN(64), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_EN(1), .ZERO_REG(31), .BYPASS(1)) dut_a (
    .CLK(clk), .RESET(rst), .REG_WRITE(a_we), .write_reg(a_wr), .writeData(a_wd),
    .read_reg(a_rr), .read_data(a_rd), .read_busy(a_rb), .ALLOC(a_al), .alloc_reg(a_ar), .busy_vec(a_bv)
  );
  register_file_mp #(.XLEN(32), .NUM_REGS(20), .NUM_RD(4), .NUM_WR(1), .ZERO_EN(1), .ZERO_REG(31), .BYPASS(0)) dut_b (
    .CLK(clk), .RESET(rst), .REG_WRITE(b_we), .write_reg(b_wr), .writeData(b_wd),
    .read_reg(b_rr), .read_data(b_rd), .read_busy(b_rb), .ALLOC(b_al), .alloc_reg(b_ar), .busy_vec(b_bv)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    chk("reset_a_rd", a_rd, 0);
    chk("reset_a_bv", a_bv, 0);
    chk("reset_a_rb", a_rb, 0);
    chk("reset_b_rd", b_rd, 0);
    a_we = 2'b01; a_wr = {5'd0, 5'd4}; a_wd = {64'd0, 64'h1234}; a_rr = {5'd0, 5'd4};
    #1 chk("reset_no_bypass", a_rd, 0);
    a_we = '0;
    tick();
    rst = 1'b0;
    a_we = 2'b01; a_wr = {5'd0, 5'd2}; a_wd = {64'd0, 64'd99999}; a_rr = {5'd0, 5'd2};
    b_we = 1'b1; b_wr = 5'd2; b_wd = 32'd99999; b_rr = {15'd0, 5'd2};
    #1 chk("a_x2_bypass", a_rd[63:0], 99999);
    chk("b_x2_before_edge", b_rd[31:0], 0);
    tick();
    a_we = '0; b_we = '0;
    #1 chk("b_x2_after_edge", b_rd[31:0], 99999);
    chk("a_x2_stored", a_rd[63:0], 99999);
    a_we = 2'b11; a_wr = {5'd5, 5'd5}; a_wd = {64'h22, 64'h11}; a_rr = {5'd5, 5'd2};
    #1 chk("dual_bypass", a_rd[127:64], 64'h22);
    tick();
    a_we = '0;
    #1 chk("dual_stored", a_rd[127:64], 64'h22);
    a_al = 1'b1; a_ar = 5'd7; a_rr = {5'd5, 5'd7};
    #1 chk("busy_before_alloc", a_rb, 0);
    tick();
    a_al = 1'b0;
    #1 chk("alloc_bv7", a_bv, 32'h80);
    chk("alloc_rb7", a_rb, 2'b01);
    a_we = 2'b10; a_wr = {5'd7, 5'd0}; a_wd = {64'h77, 64'd0};
    #1 chk("write_rb7_bypass", a_rb, 0);
    chk("write_bv7_pending", a_bv, 32'h80);
    tick();
    a_we = '0;
    #1 chk("write_bv7_cleared", a_bv, 0);
    chk("x7_stored", a_rd[63:0], 64'h77);
    a_al = 1'b1; a_ar = 5'd9; a_we = 2'b01; a_wr = {5'd0, 5'd9}; a_wd = {64'd0, 64'h55}; a_rr = {5'd9, 5'd9};
    tick();
    a_al = 1'b0; a_we = '0;
    #1 chk("collide_x9_data", a_rd[63:0], 64'h55);
    chk("collide_bv9", a_bv, 32'h200);
    chk("collide_rb9", a_rb, 2'b11);
    a_we = 2'b01; a_wr = {5'd0, 5'd31}; a_wd = {64'd0, 64'd99999}; a_al = 1'b1; a_ar = 5'd31; a_rr = {5'd31, 5'd9};
    #1 chk("xzr_bypass", a_rd[127:64], 0);
    chk("xzr_rb", a_rb, 2'b01);
    tick();
    a_we = '0; a_al = 1'b0;
    #1 chk("xzr_stored", a_rd[127:64], 0);
    chk("xzr_bv", a_bv, 32'h200);
    a_we = 2'b01; a_wr = {5'd0, 5'd3}; a_wd = {64'd0, 64'hAB}; a_rr = {5'd9, 5'd2};
    #1 rst = 1'b1;
    #1 chk("midreset_rd", a_rd, 0);
    chk("midreset_bv", a_bv, 0);
    chk("midreset_rb", a_rb, 0);
    tick();
    rst = 1'b0; a_we = '0; a_rr = {5'd3, 5'd2};
    #1 chk("postreset_regs", a_rd, 0);
    chk("postreset_b_x2", b_rd[31:0], 0);
    for (int i = 0; i < 20; i++) begin
      b_we = 1'b1; b_wr = 5'(i); b_wd = 32'hA000_0000 + 32'(i) * 32'h111;
      tick();
    end
    b_we = 1'b1; b_wr = 5'd25; b_wd = 32'hDEAD;
    tick();
    b_we = '0;
    b_rr = {5'd19, 5'd12, 5'd7, 5'd3};
    #1 chk("sweep_rd4", b_rd, {32'hA0001443, 32'hA0000CCC, 32'hA0000777, 32'hA0000333});
    b_rr = {5'd31, 5'd25, 5'd20, 5'd0};
    #1 chk("sweep_oob", b_rd, {32'd0, 32'd0, 32'd0, 32'hA0000000});
    chk("sweep_bv", b_bv, 0);
    chk("sweep_rb", b_rb, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
